pixel_scan_controller: RTL and testbench

Sequences the readout of a stored image to the two-digit hex display, one pixel per tick. Holds a pixel index and, at the programmed rate or on a manual step, reads that address from the synchronous image RAM. It registers the returned byte and presents it with a one-cycle strobe that feeds `pixel_data_in` / `new_data_tick` of the 7-segment display driver. It sits between the frame memory and the display driver in the top level.

---
 rtl/pixel_scan_controller_if.sv | 21 ++
 rtl/pixel_scan_controller.sv | 137 +++++++++++++
 tb/tb_pixel_scan_controller.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pixel_scan_controller_if.sv
// ---------------------------------------------------------------------------
// pixel_scan_controller_if
//   Read-only link between the scan controller and the synchronous image RAM.
//   The RAM returns read data one cycle after the read enable.
//
//   mem_rd_en  : read enable, driven by the controller
//   mem_addr   : read address (ADDR_W bits), driven by the controller
//   mem_rdata  : read data (8 bits), driven by the RAM
//
//   Modports: master = controller side, slave = RAM side.
// ---------------------------------------------------------------------------
interface pixel_scan_controller_if #(
  parameter int ADDR_W = 15
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;

  modport master (output mem_rd_en, output mem_addr, input  mem_rdata);
  modport slave  (input  mem_rd_en, input  mem_addr, output mem_rdata);
endinterface

// File: rtl/pixel_scan_controller.sv
// ---------------------------------------------------------------------------
// pixel_scan_controller
//   Reads a stored image out one pixel per trigger and hands each byte to the
//   hex display driver together with a one-cycle strobe. The trigger is the
//   rate divider in automatic mode or a manual step pulse otherwise.
//
//   Ports:
//     clk_50mhz      in   system clock, rising edge
//     rst            in   synchronous active-high reset
//     run            in   1 = automatic advance at TICK_HZ, 0 = manual
//     step           in   one-cycle pulse, fetches one pixel in manual mode
//     restart        in   one-cycle pulse, returns the pixel index to 0
//     mem            if   master side of the image RAM read port
//     pixel_data_out out  last fetched pixel, held between ticks
//     pixel_tick     out  one-cycle strobe, new pixel valid
//     cur_index      out  index of the next pixel to fetch
//     frame_done     out  one-cycle pulse with the tick of the last pixel
// ---------------------------------------------------------------------------
module pixel_scan_controller #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 1,
  parameter int NUM_PIXELS = 19200,
  parameter int ADDR_W     = 15
) (
  input  logic                     clk_50mhz,
  input  logic                     rst,
  input  logic                     run,
  input  logic                     step,
  input  logic                     restart,
  pixel_scan_controller_if.master  mem,
  output logic [7:0]               pixel_data_out,
  output logic                     pixel_tick,
  output logic [ADDR_W-1:0]        cur_index,
  output logic                     frame_done
);

  localparam int                DIV      = CLK_HZ / TICK_HZ;
  localparam int                DIV_W    = $clog2(DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIXELS - 1);

  typedef enum logic [1:0] {
    S_WAIT,
    S_READ,
    S_CAP,
    S_SHOW
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [ADDR_W-1:0] r_index;
  logic [7:0]        r_pixel;
  logic              w_auto_tick;
  logic              w_trigger;
  logic              w_rd_en;
  logic              w_tick;
  logic              w_frame_done;

  // Step is ignored while running; the divider alone paces automatic mode.
  assign w_auto_tick = run && (r_div_cnt == DIV_LAST);
  assign w_trigger   = run ? w_auto_tick : step;

  // Rate divider: free-runs while run=1, parked at 0 otherwise. Restart does
  // not touch it, so the automatic cadence survives a restart.
  // NOTE: clocked state is assigned with <= so every register samples the
  // pre-edge values of its peers, independent of block ordering.
  always_ff @(posedge clk_50mhz) begin
    if (rst || !run) begin
      r_div_cnt <= '0;
    end else if (r_div_cnt == DIV_LAST) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      r_state <= S_WAIT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and state-decoded outputs. Triggers outside S_WAIT are dropped.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_rd_en      = 1'b0;
    w_tick       = 1'b0;
    w_frame_done = 1'b0;
    unique case (r_state)
      S_WAIT: if (w_trigger) w_next_state = S_READ;
      S_READ: begin
        w_rd_en      = 1'b1;
        w_next_state = S_CAP;
      end
      S_CAP:  w_next_state = S_SHOW;
      S_SHOW: begin
        w_tick       = 1'b1;
        // A restart during the fetch has already zeroed the index, which is
        // what suppresses frame_done for that in-flight pixel.
        w_frame_done = (r_index == LAST_IDX);
        w_next_state = S_WAIT;
      end
      default: w_next_state = S_WAIT;
    endcase
  end

  // Pixel index: restart has priority over the post-show advance.
  always_ff @(posedge clk_50mhz) begin
    if (rst || restart) begin
      r_index <= '0;
    end else if (r_state == S_SHOW) begin
      r_index <= (r_index == LAST_IDX) ? '0 : r_index + 1'b1;
    end
  end

  // RAM data is valid in S_CAP (one cycle after the read in S_READ).
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      r_pixel <= 8'h00;
    end else if (r_state == S_CAP) begin
      r_pixel <= mem.mem_rdata;
    end
  end

  assign mem.mem_rd_en  = w_rd_en;
  assign mem.mem_addr   = r_index;
  assign cur_index      = r_index;
  assign pixel_data_out = r_pixel;
  assign pixel_tick     = w_tick;
  assign frame_done     = w_frame_done;

endmodule

// File: tb/tb_pixel_scan_controller.sv
// ---------------------------------------------------------------------------
// tb_pixel_scan_controller
//   Self-checking bench. Small parameters (DIV=8, 4 pixels) keep frames short.
//   The reference model describes each fetch as a trigger cycle T with fixed
//   offsets (read at T+1, data at T+3, index moves after T+3) and the divider
//   as a count of consecutive run cycles modulo DIV.
// ---------------------------------------------------------------------------
module tb_pixel_scan_controller;

  localparam int CLK_HZ     = 8;
  localparam int TICK_HZ    = 1;
  localparam int DIV        = CLK_HZ / TICK_HZ;
  localparam int NUM_PIXELS = 4;
  localparam int ADDR_W     = 4;

  logic              clk_50mhz = 1'b0;
  logic              rst       = 1'b1;
  logic              run       = 1'b0;
  logic              step      = 1'b0;
  logic              restart   = 1'b0;
  logic [7:0]        pixel_data_out;
  logic              pixel_tick;
  logic [ADDR_W-1:0] cur_index;
  logic              frame_done;

  pixel_scan_controller_if #(.ADDR_W(ADDR_W)) mem_if ();

  pixel_scan_controller #(
    .CLK_HZ    (CLK_HZ),
    .TICK_HZ   (TICK_HZ),
    .NUM_PIXELS(NUM_PIXELS),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk_50mhz     (clk_50mhz),
    .rst           (rst),
    .run           (run),
    .step          (step),
    .restart       (restart),
    .mem           (mem_if.master),
    .pixel_data_out(pixel_data_out),
    .pixel_tick    (pixel_tick),
    .cur_index     (cur_index),
    .frame_done    (frame_done)
  );

  always #5 clk_50mhz = ~clk_50mhz;

  // Synchronous image RAM: data = address + 0x10, one cycle after the read.
  always @(posedge clk_50mhz) begin
    if (mem_if.mem_rd_en) mem_if.mem_rdata <= 8'({4'h0, mem_if.mem_addr}) + 8'h10;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state (values valid in cycle 'cyc').
  int m_idx  = 0;   // index register
  int m_rc   = 0;   // consecutive cycles with run=1 before this one
  bit m_busy = 1'b0;
  int m_t    = 0;   // trigger cycle of the current fetch
  int m_addr = 0;   // address latched at T+1
  int m_data = 0;   // presented pixel

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Called at a negedge: check this cycle's outputs, drive this cycle's
  // inputs, advance the model, move to the next negedge.
  task automatic do_cycle(input bit i_run, input bit i_step, input bit i_restart, input bit i_rst);
    bit busy, e_rd, e_tick, e_fd, auto_t, trig;
    busy   = m_busy && (cyc <= m_t + 3);
    e_rd   = busy && (cyc == m_t + 1);
    e_tick = busy && (cyc == m_t + 3);
    e_fd   = e_tick && (m_idx == NUM_PIXELS - 1);

    check("mem_rd_en",      32'(mem_if.mem_rd_en), 32'(e_rd));
    check("mem_addr",       32'(mem_if.mem_addr),  32'(m_idx));
    check("cur_index",      32'(cur_index),        32'(m_idx));
    check("pixel_tick",     32'(pixel_tick),       32'(e_tick));
    check("frame_done",     32'(frame_done),       32'(e_fd));
    check("pixel_data_out", 32'(pixel_data_out),   32'(m_data));

    run     = i_run;
    step    = i_step;
    restart = i_restart;
    rst     = i_rst;

    if (i_rst) begin
      m_idx  = 0;
      m_rc   = 0;
      m_busy = 1'b0;
      m_data = 0;
    end else begin
      if (busy && cyc == m_t + 1) m_addr = m_idx;
      if (busy && cyc == m_t + 2) m_data = (m_addr + 16) % 256;
      auto_t = i_run && ((m_rc % DIV) == DIV - 1);
      trig   = i_run ? auto_t : i_step;
      if (e_tick) m_idx = i_restart ? 0 : (m_idx + 1) % NUM_PIXELS;
      else if (i_restart) m_idx = 0;
      m_rc = i_run ? m_rc + 1 : 0;
      if (trig && !busy) begin
        m_busy = 1'b1;
        m_t    = cyc;
      end else begin
        m_busy = busy;
      end
    end

    cyc++;
    @(posedge clk_50mhz);
    @(negedge clk_50mhz);
  endtask

  initial begin
    bit r_run;
    rst = 1'b1;
    repeat (3) @(posedge clk_50mhz);
    @(negedge clk_50mhz);

    // Idle after reset: outputs stay at reset values, no reads.
    repeat (100) do_cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Automatic mode across more than one frame, then drain.
    repeat (60) do_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (6)  do_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (4)  do_cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Manual steps at 0, 2, 10: the one at 2 lands mid-fetch and is dropped.
    for (int c = 0; c < 16; c++) do_cycle(1'b0, (c == 0) || (c == 2) || (c == 10), 1'b0, 1'b0);

    // Index is 2: restart in the S_CAP cycle, then one more step reads addr 0.
    for (int c = 0; c < 8; c++) do_cycle(1'b0, c == 0, c == 2, 1'b0);
    for (int c = 0; c < 6; c++) do_cycle(1'b0, c == 0, 1'b0, 1'b0);

    // Reset in the S_READ cycle abandons the fetch.
    for (int c = 0; c < 8; c++) do_cycle(1'b0, c == 0, 1'b0, c == 1);

    // Randomized mix of modes, steps, restarts and occasional resets.
    r_run = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(63) == 0) r_run = ~r_run;
      do_cycle(r_run, $urandom_range(5) == 0, $urandom_range(39) == 0, $urandom_range(499) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
